aes_decrypt_iter: RTL and testbench
===================================

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter Nr, default Nk+6, number of rounds.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  ciphertext block offered.
REQ-006 SHALL have port in_ready  output  1  block can be accepted.
REQ-007 SHALL have port ciphertext  input  128  [0:127], byte 0 at bits [0:7].
REQ-008 SHALL have port round_keys  input  128*(Nr+1)  [0:128*(Nr+1)-1]; round key i at bits [128*i : 128*i+127], key 0 first.
REQ-009 SHALL have port out_valid  output  1  plaintext available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts plaintext.
REQ-011 SHALL have port plaintext  output  128  [0:127], decrypted block.
REQ-012 SHALL have port round_state  output  128  current internal state, for display/debug.
REQ-013 SHALL have port round_num  output  4  round index about to be applied (Nr-1 down to 0).

Function
REQ-014 SHALL implement FSM with states IDLE, ROUND, DONE.
REQ-015 In IDLE, in_ready SHALL be 1; all other states in_ready SHALL be 0.
REQ-016 Accept SHALL occur on an edge where state=IDLE and in_valid=1; state register <= ciphertext XOR round key Nr; round_num <= Nr-1; FSM -> ROUND.
REQ-017 In ROUND with round_num=r>=1, each edge SHALL apply state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR round key r); round_num <= r-1.
REQ-018 In ROUND with round_num=0, the edge SHALL apply state <= InvSubBytes(InvShiftRows(state)) XOR round key 0 (no InvMixColumns); FSM -> DONE.
REQ-019 Latency SHALL be exactly Nr edges from the accept edge to the edge that enters DONE; out_valid SHALL be 1 exactly while in DONE.
REQ-020 plaintext SHALL equal the state register in DONE and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE, an edge with out_ready=1 SHALL return FSM to IDLE; no new block SHALL be accepted on that same edge (minimum period Nr+2 cycles).
REQ-022 in_valid while not in IDLE SHALL be ignored; ciphertext SHALL be sampled only on the accept edge.
REQ-023 round_keys SHALL NOT be latched; caller holds them stable from accept edge through DONE entry.
REQ-024 InvShiftRows SHALL rotate row n right by n byte positions (FIPS-197 5.3.1), state byte k in row k mod 4, column k div 4.
REQ-025 InvSubBytes SHALL use the FIPS-197 inverse S-box (table, combinational, 16 parallel lookups).
REQ-026 InvMixColumns SHALL multiply each column by {0e,0b,0d,09} over GF(2^8), polynomial 0x11b.
REQ-027 round_state SHALL equal the state register at all times; round_num SHALL be 0 in IDLE and DONE.

Reset
REQ-028 When reset=1 at an edge: FSM -> IDLE, state register <= 0, round_num <= 0, out_valid=0, in_ready=1 after the edge.
REQ-029 Reset SHALL take priority over accept, round progress and output handshake; a block in flight SHALL be discarded with no out_valid pulse.

Verification
REQ-030 Nk=4, keys from 000102..0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_valid 10 edges after accept, plaintext 00112233445566778899aabbccddeeff.
REQ-031 Nk=6, keys from 000102..17, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191 -> out_valid after 12 edges, plaintext 00112233445566778899aabbccddeeff.
REQ-032 Nk=8, keys from 000102..1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> out_valid after 14 edges, plaintext 00112233445566778899aabbccddeeff.
REQ-033 Nk=4, out_ready=0 for 5 cycles after DONE -> out_valid and plaintext held; in_ready=0; in_valid pulses with other data ignored; IDLE one edge after out_ready=1.
REQ-034 Nk=4, reset asserted at round_num=5 -> next cycle in_ready=1, out_valid=0, round_state=0; fresh REQ-030 block then decrypts correctly.
REQ-035 Nk=4, per-round check: round_state after first ROUND edge equals FIPS-197 Appendix C.1 inverse-round-1 output, and each subsequent round matches the Appendix C.1 inverse cipher trace.

Source files
------------

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one decryption round per clock, state held in a single 128-bit register.
// Latency: Nr edges from the accept edge to DONE; a new block can start Nr+2 cycles after the previous one.
// Backpressure: in_ready only in IDLE; plaintext is held in DONE until out_ready is seen on an edge.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - ciphertext handshake (accept when IDLE and in_valid)
//   ciphertext [0:127]    - input block, byte 0 at bits [0:7]
//   round_keys            - expanded key schedule, round key i at bits [128*i +: 128]; not latched
//   out_valid / out_ready - plaintext handshake (out_valid exactly while in DONE)
//   plaintext [0:127]     - decrypted block
//   round_state, round_num - debug view of the state register and the next round index
module aes_decrypt_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:127]          ciphertext,
  input  logic [0:128*(Nr+1)-1] round_keys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:127]          plaintext,
  output logic [0:127]          round_state,
  output logic [3:0]            round_num
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  fsm_t         fsm_next;
  logic [0:127] state;
  logic [3:0]   rnum;

  localparam logic [7:0] INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; byte 0 of the column sits in [31:24].
  // The 09/0b/0d/0e multiples are built from the shared x2/x4/x8 chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [0:127] rk_cur;
  logic [0:127] shifted;
  logic [0:127] subbed;
  logic [0:127] keyed;
  logic [0:127] mixed;

  always_comb begin
    rk_cur  = round_keys[128*int'(rnum) +: 128];
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    // Byte k is row k%4, column k/4; row r rotates right by r, so the byte
    // landing in column c comes from column (c - r) mod 4.
    for (int k = 0; k < 16; k++) begin
      shifted[8*k +: 8] = state[8*(4*(((k/4) - (k%4) + 4) % 4) + (k%4)) +: 8];
    end
    for (int k = 0; k < 16; k++) begin
      subbed[8*k +: 8] = INV_SBOX[shifted[8*k +: 8]];
    end
    keyed = subbed ^ rk_cur;
    for (int c = 0; c < 4; c++) begin
      mixed[32*c +: 32] = inv_mix_col(keyed[32*c +: 32]);
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_next = ROUND;
      ROUND:   if (rnum == 4'd0) fsm_next = DONE;
      DONE:    if (out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
      rnum  <= '0;
    end else if (fsm == IDLE && in_valid) begin
      state <= ciphertext ^ round_keys[128*Nr +: 128];
      rnum  <= 4'(Nr - 1);
    end else if (fsm == ROUND) begin
      // The last round (key 0) skips InvMixColumns; rnum stays at 0 afterwards.
      state <= (rnum == 4'd0) ? keyed : mixed;
      if (rnum != 4'd0) rnum <= rnum - 4'd1;
    end
  end

  assign in_ready    = (fsm == IDLE);
  assign out_valid   = (fsm == DONE);
  assign plaintext   = state;
  assign round_state = state;
  assign round_num   = rnum;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
module tb_aes_decrypt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                in_valid;
  logic                out_ready;
  logic [0:127]        ciphertext;
  logic [0:128*11-1]   rk4;
  logic [0:128*13-1]   rk6;
  logic [0:128*15-1]   rk8;

  logic         in_ready4, out_valid4, in_ready6, out_valid6, in_ready8, out_valid8;
  logic [0:127] pt4, rs4, pt6, rs6, pt8, rs8;
  logic [3:0]   rn4, rn6, rn8;

  aes_decrypt_iter #(.Nk(4)) d4 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .ciphertext(ciphertext), .round_keys(rk4), .out_valid(out_valid4), .out_ready(out_ready),
    .plaintext(pt4), .round_state(rs4), .round_num(rn4));
  aes_decrypt_iter #(.Nk(6)) d6 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready6),
    .ciphertext(ciphertext), .round_keys(rk6), .out_valid(out_valid6), .out_ready(out_ready),
    .plaintext(pt6), .round_state(rs6), .round_num(rn6));
  aes_decrypt_iter #(.Nk(8)) d8 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .ciphertext(ciphertext), .round_keys(rk8), .out_valid(out_valid8), .out_ready(out_ready),
    .plaintext(pt8), .round_state(rs8), .round_num(rn8));

  // View of the instance under test.
  int           cur_nk;
  logic         sel_in_ready, sel_out_valid;
  logic [0:127] sel_pt, sel_rs;
  logic [3:0]   sel_rn;
  always_comb begin
    sel_in_ready = in_ready4; sel_out_valid = out_valid4; sel_pt = pt4; sel_rs = rs4; sel_rn = rn4;
    if (cur_nk == 6) begin
      sel_in_ready = in_ready6; sel_out_valid = out_valid6; sel_pt = pt6; sel_rs = rs6; sel_rn = rn6;
    end else if (cur_nk == 8) begin
      sel_in_ready = in_ready8; sel_out_valid = out_valid8; sel_pt = pt8; sel_rs = rs8; sel_rn = rn8;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: forward AES from first principles ----------------
  logic [7:0]   sbox [0:255];
  logic [31:0]  w    [0:59];
  logic [0:127] ks   [0:14];
  logic [0:127] srow [0:14];   // state after ShiftRows of each forward round

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic expand(input int nk, input logic [0:255] key);
    int nr;
    logic [31:0] t;
    logic [7:0] rc;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic encrypt(input int nr, input logic [0:127] pt, output logic [0:127] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ ks[0][8*k +: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
      for (int k = 0; k < 16; k++) s[k] = t[4*(((k/4) + (k%4)) % 4) + (k%4)];
      for (int k = 0; k < 16; k++) srow[rnd][8*k +: 8] = s[k];
      if (rnd < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ ks[rnd][8*k +: 8];
    end
    for (int k = 0; k < 16; k++) ct[8*k +: 8] = s[k];
  endtask

  // Expand a key and drive the schedule to the matching instance.
  task automatic prep(input int nk, input logic [0:255] key);
    expand(nk, key);
    for (int i = 0; i <= nk + 6; i++) begin
      if (nk == 4)      rk4[128*i +: 128] = ks[i];
      else if (nk == 6) rk6[128*i +: 128] = ks[i];
      else              rk8[128*i +: 128] = ks[i];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready4 && in_ready6 && in_ready8) && n < 60) begin
      tick();
      n++;
    end
    if (!(in_ready4 && in_ready6 && in_ready8)) begin
      total++;
      $display("FAIL idle-timeout: got in_ready %b%b%b expected 111", in_ready4, in_ready6, in_ready8);
    end
  endtask

  // Full transaction with per-round trace, latency, hold and release checks.
  task automatic run_block(input int nk, input logic [0:127] ct, input logic [0:127] exp_pt,
                           input int stall, input string tag);
    int nr, edges;
    logic [0:127] model_ct, held;
    nr = nk + 6;
    encrypt(nr, exp_pt, model_ct);
    cur_nk = nk;
    wait_idle();
    ciphertext = ct; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    check({tag, " accept-state"}, sel_rs, srow[nr]);
    check({tag, " accept-rnum"}, 128'(sel_rn), 128'(nr - 1));
    check({tag, " busy-in_ready"}, 128'(sel_in_ready), 128'd0);
    edges = 0;
    while (!sel_out_valid && edges < 40) begin
      tick();
      edges++;
      if (!sel_out_valid && edges < nr) begin
        check($sformatf("%s trace-state-%0d", tag, edges), sel_rs, srow[nr - edges]);
        check($sformatf("%s trace-rnum-%0d", tag, edges), 128'(sel_rn), 128'(nr - 1 - edges));
      end
    end
    check({tag, " latency"}, 128'(edges), 128'(nr));
    check({tag, " plaintext"}, sel_pt, exp_pt);
    check({tag, " done-rnum"}, 128'(sel_rn), 128'd0);
    held = sel_pt;
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        tick();
        check($sformatf("%s hold-valid-%0d", tag, i), 128'(sel_out_valid), 128'd1);
        check($sformatf("%s hold-data-%0d", tag, i), sel_pt, held);
        check($sformatf("%s hold-in_ready-%0d", tag, i), 128'(sel_in_ready), 128'd0);
      end
      out_ready = 1'b1;
    end
    // in_valid high on the release edge must not start a new block.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, " release-idle"}, 128'(sel_in_ready), 128'd1);
    check({tag, " release-out_valid"}, 128'(sel_out_valid), 128'd0);
  endtask

  typedef struct {
    int           nk;
    logic [0:127] ct;
    logic [0:127] pt;
  } vec_t;

  vec_t         vecs [3];
  logic [0:255] seq_key;
  logic [0:255] rnd_key;
  logic [0:127] rnd_pt, rnd_ct;
  int           n, seen, nk_r;

  initial begin
    vecs[0] = '{4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{6, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{8, 128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
    for (int i = 0; i < 32; i++) seq_key[8*i +: 8] = 8'(i);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ciphertext = '0;
    rk4 = '0; rk6 = '0; rk8 = '0; cur_nk = 4;
    build_sbox();
    tick(); tick();
    check("reset in_ready", 128'({in_ready4, in_ready6, in_ready8}), 128'b111);
    check("reset out_valid", 128'({out_valid4, out_valid6, out_valid8}), 128'b000);
    check("reset state", rs4 | rs6 | rs8, 128'd0);
    check("reset rnum", 128'({rn4, rn6, rn8}), 128'd0);
    reset = 1'b0;
    tick();

    // Known-answer vectors for all three key sizes, with per-round trace.
    for (int v = 0; v < 3; v++) begin
      prep(vecs[v].nk, seq_key);
      run_block(vecs[v].nk, vecs[v].ct, vecs[v].pt, 0, $sformatf("kat-nk%0d", vecs[v].nk));
    end

    // Consumer stall: output held for five cycles while in_valid pulses are ignored.
    prep(4, seq_key);
    run_block(4, vecs[0].ct, vecs[0].pt, 5, "stall");

    // Reset while a block is mid-flight.
    prep(4, seq_key);
    cur_nk = 4;
    wait_idle();
    ciphertext = vecs[0].ct; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rn4 != 4'd5 && n < 20) begin
      tick();
      n++;
    end
    check("midflight rnum", 128'(rn4), 128'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset in_ready", 128'(in_ready4), 128'd1);
    check("midreset out_valid", 128'(out_valid4), 128'd0);
    check("midreset state", rs4, 128'd0);
    check("midreset rnum", 128'(rn4), 128'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid4) seen = 1;
    end
    check("midreset no-pulse", 128'(seen), 128'd0);
    run_block(4, vecs[0].ct, vecs[0].pt, 0, "post-reset");

    // Random keys and plaintexts, encrypted by the model and decrypted by the DUT.
    for (int it = 0; it < 6; it++) begin
      nk_r = 4 + 2 * int'($urandom_range(0, 2));
      rnd_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rnd_pt  = {$urandom, $urandom, $urandom, $urandom};
      prep(nk_r, rnd_key);
      encrypt(nk_r + 6, rnd_pt, rnd_ct);
      run_block(nk_r, rnd_ct, rnd_pt, int'($urandom_range(0, 3)), $sformatf("rand%0d-nk%0d", it, nk_r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
